// File: rtl/qdec_reg_wr_arb_pkg.sv
// Shared CABAC-hierarchy definitions: arbiter state encoding and requester indices.
package qdec_cabac_package;

  typedef enum logic [1:0] {
    IDLE_ARB = 2'd0,
    XFER_ARB = 2'd1,
    LOCK_ARB = 2'd2
  } t_state_arb;

  localparam int REQ_VPS     = 0;
  localparam int REQ_SPS     = 1;
  localparam int REQ_PPS     = 2;
  localparam int REQ_SEI     = 3;
  localparam int REQ_SLICE   = 4;
  localparam int NUM_REG_REQ = 5;

endpackage

// File: rtl/qdec_reg_wr_arb_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after start, wrapping.
module qdec_rr_pick #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] win,
  output logic             any
);

  logic [IDX_W-1:0] base;
  logic [2*N-1:0]   dbl;
  int               w;

  // Out-of-range start pointers fall back to index 0 so the picker never selects a missing requester.
  assign base = (int'(start) >= N) ? '0 : start;

  always_comb begin
    dbl   = {req, req} >> base;
    w     = 0;
    any   = 1'b0;
    win   = '0;
    grant = '0;
    for (int k = 0; k < N; k++) begin
      if (!any && dbl[k]) begin
        any = 1'b1;
        w   = int'(base) + k;
        if (w >= N) w = w - N;
      end
    end
    if (any) begin
      win   = IDX_W'(w);
      grant = N'(1) << win;
    end
  end

endmodule

// File: rtl/qdec_reg_wr_arb.sv
// Round-robin arbiter for the decoder's single control-register write port.
// Optional burst lock enabled by defining QDEC_REG_ARB_LOCK_EN.
module qdec_reg_wr_arb
  import qdec_cabac_package::*;
#(
  parameter int NUM_REQ = 5,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_vld,
  output logic [NUM_REQ-1:0]         req_rdy,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_lock,
  output logic                       reg_wr_vld,
  input  logic                       reg_wr_rdy,
  output logic [ADDR_W-1:0]          reg_wr_addr,
  output logic [DATA_W-1:0]          reg_wr_data,
  output logic [$clog2(NUM_REQ)-1:0] reg_wr_src,
  output logic                       busy,
  output logic [1:0]                 arb_state
);

  localparam int SRC_W = $clog2(NUM_REQ);

  // Handshake: a requester's beat transfers in a cycle where its req_vld and req_rdy are
  // both high; the output beat transfers where reg_wr_vld and reg_wr_rdy are both high.
  // req_rdy depends on reg_wr_rdy combinationally, never the reverse.

  t_state_arb         state_q, state_d;
  logic [SRC_W-1:0]   rr_ptr_q;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   win;
  logic               any;
  logic               load_ok;
  logic               accept;
  logic               win_lock;
  logic [SRC_W-1:0]   next_ptr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

`ifdef QDEC_REG_ARB_LOCK_EN
  logic [SRC_W-1:0]   owner_q;
  logic [NUM_REQ-1:0] owner_mask;

  assign owner_mask = NUM_REQ'(1) << owner_q;
  // While locked only the owner may win, even when its req_vld is low.
  assign eligible   = (state_q == LOCK_ARB) ? (req_vld & owner_mask) : req_vld;
  assign win_lock   = |(req_lock & grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= '0;
    end else if (accept && win_lock) begin
      owner_q <= win;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = ^req_lock;
  assign eligible    = req_vld;
  assign win_lock    = 1'b0;
`endif

  qdec_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (SRC_W)
  ) u_pick (
    .req   (eligible),
    .start (rr_ptr_q),
    .grant (grant),
    .win   (win),
    .any   (any)
  );

  assign load_ok  = !reg_wr_vld || reg_wr_rdy;
  assign accept   = load_ok && any && !rst;
  assign req_rdy  = grant & {NUM_REQ{load_ok && !rst}};
  assign next_ptr = (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_ARB, XFER_ARB: begin
        if (accept)          state_d = win_lock ? LOCK_ARB : XFER_ARB;
        else if (reg_wr_rdy) state_d = IDLE_ARB;
      end
      // The lock survives an empty output; only an owner beat without lock releases it.
      LOCK_ARB: begin
        if (accept && !win_lock) state_d = XFER_ARB;
      end
      default: state_d = IDLE_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE_ARB;
      rr_ptr_q    <= '0;
      reg_wr_vld  <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      reg_wr_src  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        reg_wr_vld  <= 1'b1;
        reg_wr_addr <= sel_addr;
        reg_wr_data <= sel_data;
        reg_wr_src  <= win;
      end else if (reg_wr_rdy) begin
        reg_wr_vld  <= 1'b0;
      end
      // A locking beat freezes the pointer; the releasing beat is the owner, so win+1 applies.
      if (accept && !win_lock) rr_ptr_q <= next_ptr;
    end
  end

  assign busy      = reg_wr_vld || (state_q == LOCK_ARB);
  assign arb_state = state_q;

endmodule

// File: tb/tb_qdec_reg_wr_arb.sv
// Bench for qdec_reg_wr_arb: directed scenarios plus randomized traffic against a queue-based model.
module tb_qdec_reg_wr_arb;
  import qdec_cabac_package::*;

  localparam int NR = 5;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 3;
  localparam int BW = AW + DW + SW;
`ifdef QDEC_REG_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_vld = '0;
  logic [NR-1:0]   req_rdy;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_lock = '0;
  logic            reg_wr_vld;
  logic            reg_wr_rdy = 1'b0;
  logic [AW-1:0]   reg_wr_addr;
  logic [DW-1:0]   reg_wr_data;
  logic [SW-1:0]   reg_wr_src;
  logic            busy;
  logic [1:0]      arb_state;

  int checks = 0;
  int errors = 0;

  qdec_reg_wr_arb #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_lock    (req_lock),
    .reg_wr_vld  (reg_wr_vld),
    .reg_wr_rdy  (reg_wr_rdy),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_src  (reg_wr_src),
    .busy        (busy),
    .arb_state   (arb_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic lk);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req_lock[i]          = lk;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req_vld  = '0;
    req_lock = '0;
    tick();
    rst      = 1'b0;
  endtask

  // Scoreboard model: the held output beat lives in exp_q (depth 0 or 1);
  // rotation pointer and lock owner are plain integers.
  logic [BW-1:0] exp_q[$];
  int  m_ptr    = 0;
  int  m_owner  = 0;
  bit  m_locked = 1'b0;

  always @(negedge clk) begin : model_cmp
    bit            ov;
    bit            lok;
    bit            lk;
    int            w;
    int            idx;
    logic [NR-1:0] elig;
    logic [NR-1:0] exp_rdy;
    logic [BW-1:0] hd;
    ov   = (exp_q.size() > 0);
    lok  = !ov || reg_wr_rdy;
    elig = m_locked ? (req_vld & (NR'(1) << m_owner)) : req_vld;
    w    = -1;
    for (int k = 0; k < NR; k++) begin
      idx = (m_ptr + k) % NR;
      if (w < 0 && elig[idx]) w = idx;
    end
    exp_rdy = (!rst && lok && w >= 0) ? (NR'(1) << w) : '0;
    check("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    check("reg_wr_vld", 64'(reg_wr_vld), 64'(ov));
    check("busy", 64'(busy), 64'(ov || m_locked));
    check("arb_state", 64'(arb_state), m_locked ? 64'd2 : (ov ? 64'd1 : 64'd0));
    if (ov) begin
      hd = exp_q[0];
      check("reg_wr_addr", 64'(reg_wr_addr), 64'(hd[BW-1 -: AW]));
      check("reg_wr_data", 64'(reg_wr_data), 64'(hd[DW+SW-1 -: DW]));
      check("reg_wr_src", 64'(reg_wr_src), 64'(hd[SW-1:0]));
    end
    // Advance the model to what the next rising edge must produce.
    if (rst) begin
      exp_q.delete();
      m_ptr    = 0;
      m_locked = 1'b0;
    end else begin
      if (ov && reg_wr_rdy) void'(exp_q.pop_front());
      if (exp_rdy != '0) begin
        exp_q.push_back({req_addr[w*AW +: AW], req_data[w*DW +: DW], SW'(w)});
        lk = LOCK_EN && req_lock[w];
        if (m_locked) begin
          if (!lk) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % NR;
          end
        end else if (lk) begin
          m_locked = 1'b1;
          m_owner  = w;
        end else begin
          m_ptr = (w + 1) % NR;
        end
      end
    end
  end

  int lock_src[$];
  int exp_lock[$];
  int exp_full[7] = '{0, 1, 2, 3, 4, 0, 1};
  int sei_k;
  int nb;
  bit sei_acc;
  bit sei_locks[3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_vld", 64'(reg_wr_vld), 64'd0);
    check("rst_addr", 64'(reg_wr_addr), 64'd0);
    check("rst_data", 64'(reg_wr_data), 64'd0);
    check("rst_src", 64'(reg_wr_src), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_rdy", 64'(req_rdy), 64'd0);

    // Single SPS beat
    tick();
    reg_wr_rdy = 1'b1;
    set_req(REQ_SPS, 32'h10, 32'hAB, 1'b0);
    req_vld = 5'b00010;
    @(negedge clk);
    check("single_rdy", 64'(req_rdy), 64'h2);
    tick();
    req_vld = '0;
    @(negedge clk);
    check("single_vld", 64'(reg_wr_vld), 64'd1);
    check("single_addr", 64'(reg_wr_addr), 64'h10);
    check("single_data", 64'(reg_wr_data), 64'hAB);
    check("single_src", 64'(reg_wr_src), 64'd1);
    tick();
    @(negedge clk);
    check("single_idle", 64'(arb_state), 64'd0);

    // Full contention from reset
    do_reset();
    reg_wr_rdy = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, AW'(32'h100 + i), DW'(i * 7), 1'b0);
    req_vld = '1;
    for (int c = 0; c < 7; c++) begin
      tick();
      @(negedge clk);
      check("rot_vld", 64'(reg_wr_vld), 64'd1);
      check("rot_src", 64'(reg_wr_src), 64'(exp_full[c]));
    end

    // Backpressure with VPS and PPS pending
    do_reset();
    reg_wr_rdy = 1'b0;
    set_req(REQ_VPS, 32'h100, 32'h1, 1'b0);
    set_req(REQ_PPS, 32'h200, 32'h2, 1'b0);
    req_vld = 5'b00101;
    tick();
    req_vld = 5'b00100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_src", 64'(reg_wr_src), 64'd0);
      check("bp_addr", 64'(reg_wr_addr), 64'h100);
      check("bp_rdy", 64'(req_rdy), 64'd0);
      tick();
    end
    reg_wr_rdy = 1'b1;
    @(negedge clk);
    check("bp_refill_rdy", 64'(req_rdy), 64'h4);
    tick();
    req_vld = '0;
    @(negedge clk);
    check("bp_second_vld", 64'(reg_wr_vld), 64'd1);
    check("bp_second_src", 64'(reg_wr_src), 64'd2);
    check("bp_second_addr", 64'(reg_wr_addr), 64'h200);

    // SEI burst (lock 1,1,0) against a continuously requesting SLICE
    do_reset();
    reg_wr_rdy = 1'b1;
    if (LOCK_EN) exp_lock = '{3, 3, 3, 4};
    else         exp_lock = '{3, 4, 3, 4, 3};
    nb    = exp_lock.size();
    sei_k = 0;
    set_req(REQ_SEI, 32'h300, 32'h30, 1'b1);
    set_req(REQ_SLICE, 32'h400, 32'h40, 1'b0);
    req_vld = 5'b11000;
    for (int c = 0; c < 20 && lock_src.size() < nb; c++) begin
      @(negedge clk);
      if (reg_wr_vld) lock_src.push_back(int'(reg_wr_src));
      sei_acc = req_rdy[REQ_SEI];
      tick();
      if (sei_acc) sei_k++;
      req_vld[REQ_SEI] = (sei_k < 3);
      if (sei_k < 3) set_req(REQ_SEI, AW'(32'h300 + sei_k), DW'(32'h30 + sei_k), sei_locks[sei_k]);
      else           req_lock[REQ_SEI] = 1'b0;
    end
    check("lock_count", 64'(lock_src.size()), 64'(nb));
    for (int i = 0; i < nb && i < lock_src.size(); i++)
      check("lock_src", 64'(lock_src[i]), 64'(exp_lock[i]));

    // Reset while stalled and (when enabled) locked
    do_reset();
    reg_wr_rdy = 1'b0;
    set_req(REQ_SEI, 32'h350, 32'h35, 1'b1);
    req_vld = 5'b01000;
    tick();
    req_vld = '1;
    tick();
    @(negedge clk);
    check("stall_busy", 64'(busy), 64'd1);
    check("stall_src", 64'(reg_wr_src), 64'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("postrst_vld", 64'(reg_wr_vld), 64'd0);
    check("postrst_busy", 64'(busy), 64'd0);
    check("postrst_grant", 64'(req_rdy), 64'h1);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_vld    = NR'($urandom_range(0, 31));
      reg_wr_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++)
        set_req(i, AW'($urandom), DW'($urandom), ($urandom_range(0, 2) == 0));
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst     = 1'b0;
    req_vld = '0;
    tick();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qdec_reg_wr_arb.md
# qdec_reg_wr_arb

Round-robin write arbiter sharing the decoder's single control-register write port among the parameter-set and header parsing sub-FSMs: VPS, SPS, PPS, SEI and slice header. It sits between those sub-FSMs and the control register block, inside the CABAC main-FSM hierarchy. It holds one registered output beat with valid/ready flow control, and can optionally lock the grant to one requester for a multi-write burst.

## Interface
Parameters:
- NUM_REQ, 5, number of requesters; index order VPS=0, SPS=1, PPS=2, SEI=3, SLICE=4
- ADDR_W, 32, register address width
- DATA_W, 32, register data width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_vld  in  NUM_REQ  per-requester write valid
- req_rdy  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed data, same packing
- req_lock  in  NUM_REQ  burst lock; honoured only with QDEC_REG_ARB_LOCK_EN
- reg_wr_vld  out  1  write beat valid toward control register
- reg_wr_rdy  in  1  control register accepts beat
- reg_wr_addr  out  ADDR_W  beat address
- reg_wr_data  out  DATA_W  beat data
- reg_wr_src  out  $clog2(NUM_REQ)  index of requester that produced the beat
- busy  out  1  output beat held or lock active

## Operation
- One output holding register (addr, data, src, vld).
- Load condition: `load_ok = !reg_wr_vld | reg_wr_rdy`.
- When `load_ok` is true, the arbiter picks a winner among req_vld, asserts that requester's req_rdy in the same cycle, and captures its beat at the clock edge.
- Round-robin pointer `rr_ptr`:
  - Search order starts at rr_ptr and wraps NUM_REQ-1 -> 0.
  - After each accepted beat with no lock held, rr_ptr = winner+1, wrapping to 0 after NUM_REQ-1.
- States (t_state_arb):
  - IDLE_ARB: output empty, no owner. On any accepted beat -> XFER_ARB, or -> LOCK_ARB if the beat's req_lock=1 and the macro is enabled.
  - XFER_ARB: output full. reg_wr_rdy with no new beat -> IDLE_ARB. reg_wr_rdy with a new beat -> stay (or -> LOCK_ARB on a locked beat). No reg_wr_rdy -> stay; output stable; all req_rdy=0.
  - LOCK_ARB: only the owner is eligible, even if others request and the owner's req_vld is low. An accepted owner beat with req_lock=0 releases the lock: rr_ptr = owner+1; next state XFER_ARB.
- req_rdy is never asserted while `load_ok` is false.
- busy = reg_wr_vld | (state==LOCK_ARB).

## Timing
- Reset values:
  - reg_wr_vld=0, reg_wr_addr=0, reg_wr_data=0, reg_wr_src=0
  - req_rdy=0, busy=0
  - rr_ptr=0, state=IDLE_ARB
- Latency: req_vld&req_rdy in cycle N -> reg_wr_vld in cycle N+1.
- Throughput: one beat per cycle while reg_wr_rdy=1.
- Output stability: reg_wr_addr/data/src hold stable while reg_wr_vld & !reg_wr_rdy.
- Drain and refill: in the same cycle, the old beat retires and the new beat loads with no bubble.
- Simultaneous requests are served in strict rotation. With all five continuously valid from reset, the order is 0,1,2,3,4,0.
- Reset mid-operation: the held beat and any lock are discarded; no beat is emitted in the cycle after rst.
- req_rdy is combinational from req_vld, rr_ptr, state and reg_wr_rdy. reg_wr_* are registered only.

## Configuration
- QDEC_REG_ARB_LOCK_EN defined:
  - req_lock is honoured; LOCK_ARB is reachable.
  - A burst from one requester (e.g. SPS writing consecutive fields) is never interleaved with another requester's beats.
- Undefined:
  - req_lock is ignored and LOCK_ARB is unreachable.
  - Arbitration is pure per-beat round-robin.

## Structure
- qdec_cabac_package:
  - t_state_arb enum {IDLE_ARB, XFER_ARB, LOCK_ARB}
  - constants REQ_VPS=0, REQ_SPS=1, REQ_PPS=2, REQ_SEI=3, REQ_SLICE=4, NUM_REG_REQ=5
- Sub-module qdec_rr_pick: combinational rotating priority picker.
  - Inputs: req vector, start pointer.
  - Outputs: one-hot grant, winner index, any.
  - Reusable by later arbiters.

## Test plan
- Single requester: SPS sends addr=0x10, data=0xAB with reg_wr_rdy=1 -> req_rdy[1] asserted that cycle; next cycle reg_wr_vld=1, addr=0x10, data=0xAB, src=1; then IDLE_ARB.
- Full contention: all five req_vld held high, reg_wr_rdy=1 -> src sequence 0,1,2,3,4,0,1 on consecutive cycles with no bubbles.
- Backpressure: reg_wr_rdy=0 for 4 cycles with VPS and PPS pending -> output frozen on first beat, all req_rdy=0; after release, beats drain back-to-back, PPS second.
- Lock (macro on): SEI sends 3 beats with lock=1,1,0 while SLICE requests -> src 3,3,3 then 4. Macro off: same stimulus -> src 3,4,3,4,3.
- Reset mid-stall: rst pulsed while reg_wr_vld=1 and lock held -> next cycle reg_wr_vld=0, busy=0, and the next grant goes to requester 0.
